// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage. Issues in-order memory requests from
//                a local pc under a credit scheme (in-flight requests plus
//                buffered instructions never exceed DEPTH), buffers responses
//                with their issuing pc and hands them to decode. A redirect
//                flushes the buffer and drops responses that are still in flight.
//                Optional feature macro: FETCH_MISALIGN_CHECK_EN (sticky trap on
//                misaligned redirect targets instead of silently aligning them).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_address_enable,
    input  logic [31:0] branch_address,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        in_decode_stall,
    output logic        out_instruction_valid,
    output logic [31:0] out_instruction,
    output logic [31:0] out_program_counter,
    output logic [31:0] out_next_program_counter,
    output logic        fetch_misaligned
);

    // Counter width must hold the value DEPTH itself; pointer width indexes DEPTH entries.
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW:0]   c_CREDITS  = (CNTW + 1)'(DEPTH);
    localparam logic [PTRW-1:0] c_LAST_PTR = PTRW'(DEPTH - 1);

    logic [31:0]     r_pc;
    logic [CNTW-1:0] r_inflight;
    logic [CNTW-1:0] r_occ;
    logic [CNTW-1:0] r_drop;
    logic [PTRW-1:0] r_head;
    logic [PTRW-1:0] r_tail;
    logic [31:0]     r_buf_instr [DEPTH];
    logic [31:0]     r_buf_pc    [DEPTH];
    // Issuing pc of each in-flight request, kept in request order.
    logic [31:0]     r_req_pc    [DEPTH];
    logic [PTRW-1:0] r_req_head;
    logic [PTRW-1:0] r_req_tail;

    logic            w_credit_ok;
    logic            w_accept;
    logic            w_stale;
    logic            w_push;
    logic            w_pop;
    logic            w_misaligned;
    logic [31:0]     w_redirect_pc;

    function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + PTRW'(1);
    endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misaligned;

    // Sticky trap: a misaligned redirect target halts fetch until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else if (branch_address_enable && (branch_address[1:0] != 2'b00)) begin
            r_misaligned <= 1'b1;
        end
    end

    assign w_redirect_pc = branch_address;
    assign w_misaligned  = r_misaligned;
`else
    logic w_unused_low_bits;

    assign w_unused_low_bits = ^branch_address[1:0];
    assign w_redirect_pc     = {branch_address[31:2], 2'b00};
    assign w_misaligned      = 1'b0;
`endif

    // Request, response and hand-off qualifiers.
    always_comb begin
        w_credit_ok           = ({1'b0, r_inflight} + {1'b0, r_occ}) < c_CREDITS;
        imem_req_valid        = !reset && w_credit_ok && !branch_address_enable && !w_misaligned;
        w_accept              = imem_req_valid && imem_req_ready;
        w_stale               = branch_address_enable || (r_drop != '0);
        w_push                = imem_resp_valid && !w_stale;
        out_instruction_valid = (r_occ != '0) && !branch_address_enable;
        w_pop                 = out_instruction_valid && !in_decode_stall;
    end

    assign imem_addr                = r_pc;
    assign out_instruction          = r_buf_instr[r_head];
    assign out_program_counter      = r_buf_pc[r_head];
    assign out_next_program_counter = r_buf_pc[r_head] + 32'd4;
    assign fetch_misaligned         = w_misaligned;

    // Control state: pc, credit counters, drop counter and buffer pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_occ      <= '0;
            r_drop     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_req_head <= '0;
            r_req_tail <= '0;
        end else begin
            // Every response retires a request, whether it is kept or dropped.
            r_inflight <= r_inflight + CNTW'(w_accept) - CNTW'(imem_resp_valid);
            if (w_accept) begin
                r_req_tail <= ptr_next(r_req_tail);
            end
            if (imem_resp_valid) begin
                r_req_head <= ptr_next(r_req_head);
            end
            if (branch_address_enable) begin
                // No request is issued in a redirect cycle, so only a response can retire here.
                r_pc   <= w_redirect_pc;
                r_occ  <= '0;
                r_head <= '0;
                r_tail <= '0;
                r_drop <= r_inflight - CNTW'(imem_resp_valid);
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (imem_resp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - CNTW'(1);
                end
                if (w_push) begin
                    r_tail <= ptr_next(r_tail);
                end
                if (w_pop) begin
                    r_head <= ptr_next(r_head);
                end
                r_occ <= r_occ + CNTW'(w_push) - CNTW'(w_pop);
            end
        end
    end

    // Storage: record each issuing pc, then pair it with its instruction word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_instr[i] <= '0;
                r_buf_pc[i]    <= '0;
                r_req_pc[i]    <= '0;
            end
        end else begin
            if (w_accept) begin
                r_req_pc[r_req_tail] <= r_pc;
            end
            if (w_push) begin
                r_buf_instr[r_tail] <= imem_resp_data;
                r_buf_pc[r_tail]    <= r_req_pc[r_req_head];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage with an in-order
//                queue memory (latency 1, responses can be held back).
//                Uses DEPTH = 3 so a latency-1 memory can sustain one
//                instruction per cycle under the strict credit rule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int          DEPTH  = 3;
    localparam logic [31:0] C_SALT = 32'hA5C3_0F69;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_address_enable;
    logic [31:0] branch_address;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        in_decode_stall;
    logic        out_instruction_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_program_counter;
    logic [31:0] out_next_program_counter;
    logic        fetch_misaligned;

    logic        hold;
    logic [31:0] q [$];
    int          n_acc;
    int          n_pop;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .branch_address_enable    (branch_address_enable),
        .branch_address           (branch_address),
        .imem_req_valid           (imem_req_valid),
        .imem_req_ready           (imem_req_ready),
        .imem_addr                (imem_addr),
        .imem_resp_valid          (imem_resp_valid),
        .imem_resp_data           (imem_resp_data),
        .in_decode_stall          (in_decode_stall),
        .out_instruction_valid    (out_instruction_valid),
        .out_instruction          (out_instruction),
        .out_program_counter      (out_program_counter),
        .out_next_program_counter (out_next_program_counter),
        .fetch_misaligned         (fetch_misaligned)
    );

    // In-order memory: data word is address ^ C_SALT, one cycle after acceptance unless held.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            if (imem_resp_valid) void'(q.pop_front());
            if (imem_req_valid && imem_req_ready) q.push_back(imem_addr);
            if (!hold && q.size() != 0) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= q[0] ^ C_SALT;
            end else begin
                imem_resp_valid <= 1'b0;
            end
        end
    end

    // Accepted-request and delivered-instruction tallies.
    always @(posedge clk) begin
        if (reset) begin
            n_acc = 0;
            n_pop = 0;
        end else begin
            if (imem_req_valid && imem_req_ready) n_acc = n_acc + 1;
            if (out_instruction_valid && !in_decode_stall) n_pop = n_pop + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset                 = 1'b1;
        branch_address_enable = 1'b0;
        branch_address        = '0;
        in_decode_stall       = 1'b0;
        imem_req_ready        = 1'b1;
        hold                  = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    // Wait (bounded) for the next delivered instruction and check it, then advance one cycle.
    task automatic next_out(input string tag, input logic [31:0] exp_pc);
        int t = 0;
        while (out_instruction_valid !== 1'b1 && t < 20) begin
            cyc();
            t++;
        end
        chk({tag, "_valid"}, 32'(out_instruction_valid), 32'd1);
        chk({tag, "_pc"}, out_program_counter, exp_pc);
        chk({tag, "_instr"}, out_instruction, exp_pc ^ C_SALT);
        chk({tag, "_npc"}, out_next_program_counter, exp_pc + 32'd4);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        reset                 = 1'b1;
        branch_address_enable = 1'b0;
        branch_address        = '0;
        in_decode_stall       = 1'b0;
        imem_req_ready        = 1'b1;
        hold                  = 1'b0;
        cyc();
        cyc();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_instruction_valid), 32'd0);
        chk("rst_instr", out_instruction, 32'd0);
        chk("rst_pc", out_program_counter, 32'd0);
        chk("rst_npc", out_next_program_counter, 32'd4);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_misaligned", 32'(fetch_misaligned), 32'd0);

        // ---------------- streaming, zero-wait memory ----------------
        reset = 1'b0;
        #1;
        chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
        chk("c0_addr", imem_addr, 32'd0);
        cyc();
        chk("c1_out_valid", 32'(out_instruction_valid), 32'd0);
        for (int k = 2; k <= 7; k++) begin
            cyc();
            chk("stream_valid", 32'(out_instruction_valid), 32'd1);
            chk("stream_pc", out_program_counter, 32'(4 * (k - 2)));
            chk("stream_instr", out_instruction, 32'(4 * (k - 2)) ^ C_SALT);
            chk("stream_npc", out_next_program_counter, 32'(4 * (k - 2) + 4));
        end

        // ---------------- decode stall for 5 cycles ----------------
        cyc();
        in_decode_stall = 1'b1;
        #1;
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", 32'(out_instruction_valid), 32'd1);
            chk("stall_head_pc", out_program_counter, 32'd24);
            chk("stall_credit", 32'((n_acc - n_pop) <= DEPTH), 32'd1);
            if (s == 2) chk("stall_req_blocked", 32'(imem_req_valid), 32'd0);
            cyc();
        end
        in_decode_stall = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("unstall_valid", 32'(out_instruction_valid), 32'd1);
            chk("unstall_pc", out_program_counter, 32'(24 + 4 * i));
            cyc();
        end

        // ---------------- redirect with 2 in flight, then a second redirect ----------------
        do_reset();
        hold = 1'b1;
        cyc();
        cyc();
        branch_address_enable = 1'b1;
        branch_address        = 32'h0000_0300;
        #1;
        chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
        chk("redir_out_valid", 32'(out_instruction_valid), 32'd0);
        cyc();
        branch_address = 32'h0000_0100;
        #1;
        chk("redir2_req_valid", 32'(imem_req_valid), 32'd0);
        cyc();
        branch_address_enable = 1'b0;
        hold                  = 1'b0;
        #1;
        chk("redir_target_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_target_addr", imem_addr, 32'h0000_0100);
        next_out("drop_first", 32'h0000_0100);
        next_out("drop_second", 32'h0000_0104);

        // ---------------- redirect coinciding with a response ----------------
        do_reset();
        cyc();
        cyc();
        cyc();
        cyc();
        branch_address_enable = 1'b1;
        branch_address        = 32'h0000_0200;
        #1;
        chk("coin_resp_present", 32'(imem_resp_valid), 32'd1);
        chk("coin_out_valid", 32'(out_instruction_valid), 32'd0);
        chk("coin_req_valid", 32'(imem_req_valid), 32'd0);
        cyc();
        branch_address_enable = 1'b0;
        #1;
        chk("coin_next_valid", 32'(imem_req_valid), 32'd1);
        chk("coin_next_addr", imem_addr, 32'h0000_0200);
        next_out("coin_first", 32'h0000_0200);
        next_out("coin_second", 32'h0000_0204);

        // ---------------- pc wrap ----------------
        do_reset();
        branch_address_enable = 1'b1;
        branch_address        = 32'hFFFF_FFFC;
        #1;
        chk("wrap_redir_req", 32'(imem_req_valid), 32'd0);
        cyc();
        branch_address_enable = 1'b0;
        #1;
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        cyc();
        chk("wrap_addr_zero", imem_addr, 32'h0000_0000);
        next_out("wrap_first", 32'hFFFF_FFFC);
        next_out("wrap_second", 32'h0000_0000);

        // ---------------- misaligned redirect ----------------
        do_reset();
        branch_address_enable = 1'b1;
        branch_address        = 32'h0000_0102;
        cyc();
        branch_address_enable = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_flag", 32'(fetch_misaligned), 32'd1);
        chk("mis_req_blocked", 32'(imem_req_valid), 32'd0);
        cyc();
        cyc();
        cyc();
        chk("mis_flag_sticky", 32'(fetch_misaligned), 32'd1);
        chk("mis_req_still_blocked", 32'(imem_req_valid), 32'd0);
        chk("mis_out_valid", 32'(out_instruction_valid), 32'd0);
`else
        chk("mis_flag", 32'(fetch_misaligned), 32'd0);
        chk("mis_req_valid", 32'(imem_req_valid), 32'd1);
        chk("mis_aligned_addr", imem_addr, 32'h0000_0100);
        next_out("mis_first", 32'h0000_0100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
